// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;
  localparam int MULT_CNT_W = 6;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {acc,q,q_1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic signed [WIDTH:0]   acc,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_1,
  input  logic signed [WIDTH:0]   m,
  output logic signed [WIDTH:0]   acc_nxt,
  output logic        [WIDTH-1:0] q_nxt,
  output logic                    q_1_nxt
);

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    unique case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    // The bit shifted out of acc becomes the new top bit of q.
    acc_nxt = sum >>> 1;
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/mult.sv
// Sequential signed WIDTH x WIDTH Booth multiplier with init/stop handshake;
// result is registered into hi/lo with a one-cycle done pulse.
module mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             init,
  input  logic             stop,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  mult_state_t                  state;
  logic signed [WIDTH:0]        m;
  logic signed [WIDTH:0]        acc;
  logic        [WIDTH-1:0]      q;
  logic                         q_1;
  logic        [MULT_CNT_W-1:0] cnt;

  logic signed [WIDTH:0]        acc_nxt;
  logic        [WIDTH-1:0]      q_nxt;
  logic                         q_1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort dominates everything, including a result about to be written.
      if (stop) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (init) begin
              m     <= $signed({a[WIDTH-1], a});
              acc   <= '0;
              q     <= b;
              q_1   <= 1'b0;
              cnt   <= MULT_CNT_W'(WIDTH);
              state <= RUN;
            end
          end
          RUN: begin
            acc <= acc_nxt;
            q   <= q_nxt;
            q_1 <= q_1_nxt;
            cnt <= cnt - MULT_CNT_W'(1);
            if (cnt == MULT_CNT_W'(1)) state <= DONE;
          end
          DONE: begin
            hi    <= acc[WIDTH-1:0];
            lo    <= q;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult.sv
// Bench for mult: directed vectors with literal expectations plus a
// cycle-level behavioural model compared on every falling edge.
module tb_mult;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        init;
  logic        stop;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  mult dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .init (init),
    .stop (stop),
    .hi   (hi),
    .lo   (lo),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Behavioural model: an accepted request yields the exact signed product
  // 33 clocks later unless aborted; requests are refused while busy.
  int                 rem;
  logic signed [63:0] pend;
  logic        [31:0] exp_hi, exp_lo;
  logic               exp_done;
  logic               model_live = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= 0; exp_done <= 1'b0; exp_hi <= '0; exp_lo <= '0; pend <= '0;
    end else if (rem != 0) begin
      if (stop) begin
        rem <= 0; exp_done <= 1'b0;
      end else begin
        rem <= rem - 1;
        if (rem == 1) begin
          exp_done <= 1'b1; exp_hi <= pend[63:32]; exp_lo <= pend[31:0];
        end else exp_done <= 1'b0;
      end
    end else begin
      exp_done <= 1'b0;
      if (init && !stop) begin
        rem  <= 33;
        pend <= $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("model_done", {31'd0, done}, {31'd0, exp_done});
      check("model_hi", hi, exp_hi);
      check("model_lo", lo, exp_lo);
    end
  end

  // Called on a falling edge; init is sampled at the next rising edge (E0).
  task automatic start(input logic [31:0] av, input logic [31:0] bv);
    a = av; b = bv; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, 33);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int saw_done;
    a = '0; b = '0; init = 1'b0; stop = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    #9 rst = 1'b0;
    @(negedge clk);
    model_live = 1'b1;

    start(32'd3, 32'd4);
    wait_done("p3x4", 32'h0000_0000, 32'h0000_000C);
    @(negedge clk);
    check("p3x4_done_clear", {31'd0, done}, 32'h0);

    start(-32'sd7, 32'd5);
    wait_done("m7x5", 32'hFFFF_FFFF, 32'hFFFF_FFDD);
    // Back-to-back issue: init sampled on the edge that clears done.
    start(32'h8000_0000, 32'h8000_0000);
    wait_done("minxmin", 32'h4000_0000, 32'h0000_0000);
    start(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done("maxxmax", 32'h3FFF_FFFF, 32'h0000_0001);
    @(negedge clk);

    // Abort: init ignored mid-run, stop at E10, prior result kept.
    start(32'd1000, 32'd1000);
    repeat (8) @(negedge clk);
    a = 32'd9; b = 32'd9; init = 1'b1;
    @(negedge clk);
    init = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done++;
      if (!done && saw_done == 0) ;
      if (rem != 0) break;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_hi_kept", hi, 32'h3FFF_FFFF);
    check("abort_lo_kept", lo, 32'h0000_0001);

    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("m1xm1", 32'h0000_0000, 32'h0000_0001);
    @(negedge clk);

    // Reset mid-operation around E20.
    start(32'd12345, 32'd678);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_done", {31'd0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("midrst_no_done", saw_done, 0);

    start(32'd6, -32'sd9);
    wait_done("p6xm9", 32'hFFFF_FFFF, 32'hFFFF_FFCA);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
